// File: rtl/reg_read_stage_pkg.sv
// Shared types and helpers for the operand-fetch (register read) stage.
//   REG_IDX_W / DATA_W / NUM_REGS : 8 x 16 register file geometry
//   CTRL_W_DEFAULT                : default width of the pass-through control bundle
//   wb_t                          : writeback snoop bundle (write enable, byte lanes, dest, data)
//   byte_merge()                  : overlays the enabled byte lanes of wdata onto d
package reg_read_stage_pkg;
  localparam int REG_IDX_W      = 3;
  localparam int DATA_W         = 16;
  localparam int NUM_REGS       = 8;
  localparam int CTRL_W_DEFAULT = 22;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    data_t;

  typedef struct packed {
    logic     we;
    logic     hb;
    logic     lb;
    reg_idx_t dest;
    data_t    data;
  } wb_t;

  function automatic data_t byte_merge(data_t d, data_t wdata, logic hb, logic lb);
    data_t r;
    r = d;
    if (hb) r[15:8] = wdata[15:8];
    if (lb) r[7:0]  = wdata[7:0];
    return r;
  endfunction
endpackage

// File: rtl/reg_read_stage_if.sv
// Bus bundle for reg_read_stage: decode-side request, RF read port, writeback snoop,
// flush, and execute-side response.
//   slave  : the stage itself
//   master : the environment (decode + RF + writeback + execute)
interface reg_read_stage_if
  import reg_read_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  reg_idx_t          in_srcA;
  reg_idx_t          in_srcB;
  reg_idx_t          rf_addrA;
  reg_idx_t          rf_addrB;
  data_t             rf_dataA;
  data_t             rf_dataB;
  logic              wb_we;
  logic              wb_hb;
  logic              wb_lb;
  reg_idx_t          wb_regDest;
  data_t             wb_dataIn;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  data_t             out_opA;
  data_t             out_opB;

  modport slave (
    input  in_valid, in_ctrl, in_srcA, in_srcB, rf_dataA, rf_dataB,
           wb_we, wb_hb, wb_lb, wb_regDest, wb_dataIn, flush, out_ready,
    output in_ready, rf_addrA, rf_addrB, out_valid, out_ctrl, out_opA, out_opB
  );

  modport master (
    output in_valid, in_ctrl, in_srcA, in_srcB, rf_dataA, rf_dataB,
           wb_we, wb_hb, wb_lb, wb_regDest, wb_dataIn, flush, out_ready,
    input  in_ready, rf_addrA, rf_addrB, out_valid, out_ctrl, out_opA, out_opB
  );
endinterface

// File: rtl/reg_read_fwd.sv
// Writeback forwarding for one operand: if the snooped writeback targets src, the
// enabled byte lanes of the writeback data replace those of d; otherwise d passes.
//   d   : operand value before forwarding
//   src : register index the operand came from
//   wb  : writeback snoop bundle
//   q   : forwarded operand
module reg_read_fwd
  import reg_read_stage_pkg::*;
(
  input  data_t    d,
  input  reg_idx_t src,
  input  wb_t      wb,
  output data_t    q
);
  always_comb begin
    q = d;
    if (wb.we && (wb.dest == src)) q = byte_merge(d, wb.data, wb.hb, wb.lb);
  end
endmodule

// File: rtl/reg_read_stage.sv
// Operand-fetch stage: reads srcA/srcB from the register file, forwards writeback byte
// lanes, and holds one registered instruction for execute with a valid/ready handshake.
// A held (stalled) instruction keeps absorbing matching writebacks so its operands never
// go stale. flush (setPC) kills the held instruction and blocks acceptance that cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : reg_read_stage_if.slave (decode in, RF port, writeback snoop, execute out)
// Build option: REG_READ_BYPASS_EN forwards writeback on accept; without it an
// instruction whose source is being written this cycle stalls one cycle and re-reads RF.
module reg_read_stage
  import reg_read_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  reg_read_stage_if.slave  bus
);
  localparam int NUM_FWD = 4;
  localparam int FWD_A   = 0;  // incoming srcA
  localparam int FWD_B   = 1;  // incoming srcB
  localparam int FWD_HA  = 2;  // held operand A
  localparam int FWD_HB  = 3;  // held operand B

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
  data_t             opa_q,   opa_d;
  data_t             opb_q,   opb_d;
  reg_idx_t          srca_q,  srca_d;
  reg_idx_t          srcb_q,  srcb_d;

  wb_t                      wb;
  data_t    [NUM_FWD-1:0]   fwd_d;
  data_t    [NUM_FWD-1:0]   fwd_q;
  reg_idx_t [NUM_FWD-1:0]   fwd_s;
  logic                     raw_stall;
  logic                     in_rdy;
  logic                     accept;

  assign bus.rf_addrA = bus.in_srcA;
  assign bus.rf_addrB = bus.in_srcB;

  always_comb begin
    wb = '{we: bus.wb_we, hb: bus.wb_hb, lb: bus.wb_lb,
           dest: bus.wb_regDest, data: bus.wb_dataIn};
    fwd_d[FWD_A]  = bus.rf_dataA;  fwd_s[FWD_A]  = bus.in_srcA;
    fwd_d[FWD_B]  = bus.rf_dataB;  fwd_s[FWD_B]  = bus.in_srcB;
    fwd_d[FWD_HA] = opa_q;         fwd_s[FWD_HA] = srca_q;
    fwd_d[FWD_HB] = opb_q;         fwd_s[FWD_HB] = srcb_q;
  end

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    reg_read_fwd u_fwd (.d(fwd_d[i]), .src(fwd_s[i]), .wb(wb), .q(fwd_q[i]));
  end

`ifdef REG_READ_BYPASS_EN
  assign raw_stall = 1'b0;
`else
  // Hold off a read of a register being written; next cycle the RF holds the new value.
  // Because of this stall the input-side forwarders can never match on an accept, so
  // their outputs equal the raw RF data in this build.
  assign raw_stall = bus.in_valid & bus.wb_we &
                     ((bus.wb_regDest == bus.in_srcA) | (bus.wb_regDest == bus.in_srcB));
`endif

  always_comb begin
    in_rdy = ~rst & ~bus.flush & (~valid_q | bus.out_ready) & ~raw_stall;
    accept = bus.in_valid & in_rdy;
  end

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = bus.in_ctrl;
      opa_d   = fwd_q[FWD_A];
      opb_d   = fwd_q[FWD_B];
      srca_d  = bus.in_srcA;
      srcb_d  = bus.in_srcB;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Stalled: refresh operands in place from any matching writeback.
      opa_d = fwd_q[FWD_HA];
      opb_d = fwd_q[FWD_HB];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = valid_q;
  assign bus.out_ctrl  = ctrl_q;
  assign bus.out_opA   = opa_q;
  assign bus.out_opB   = opb_q;
endmodule

// File: tb/tb_reg_read_stage.sv
module tb_reg_read_stage;
  import reg_read_stage_pkg::*;
  localparam int CW = CTRL_W_DEFAULT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_read_stage_if #(.CTRL_W(CW)) bus();
  reg_read_stage #(.CTRL_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Register file model: async read of pre-write value, written just after the edge.
  logic [15:0] rf [8];
  assign bus.rf_dataA = rf[bus.rf_addrA];
  assign bus.rf_dataB = rf[bus.rf_addrB];

  // What execute should currently see.
  typedef struct packed {
    logic          v;
    logic [CW-1:0] ctrl;
    logic [15:0]   a;
    logic [15:0]   b;
    logic [2:0]    sa;
    logic [2:0]    sb;
  } held_t;

  held_t         m;
  bit            m_known = 0;
  int            errs = 0;
  int            checks = 0;
  logic [CW-1:0] sbq [$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value register s would have after this cycle's writeback, applied to d.
  function automatic logic [15:0] wb_view(logic [15:0] d, logic [2:0] s);
    logic [15:0] mask;
    if (!(bus.wb_we && bus.wb_regDest == s)) return d;
    mask = (bus.wb_hb ? 16'hFF00 : 16'h0000) | (bus.wb_lb ? 16'h00FF : 16'h0000);
    return (d & ~mask) | (bus.wb_dataIn & mask);
  endfunction

  // Inputs are already applied (low clock phase). Compare, predict, advance one cycle.
  task automatic tick();
    logic  raw, exp_rdy, acc;
    held_t nx;
    #1;
`ifdef REG_READ_BYPASS_EN
    raw = 1'b0;
`else
    raw = bus.in_valid && bus.wb_we &&
          (bus.wb_regDest == bus.in_srcA || bus.wb_regDest == bus.in_srcB);
`endif
    exp_rdy = !bus.flush && (!m.v || bus.out_ready) && !raw;
    acc     = bus.in_valid && exp_rdy && !rst;
    if (m_known) begin
      chk("out_valid", bus.out_valid, m.v);
      if (m.v) begin
        chk("out_ctrl", bus.out_ctrl, m.ctrl);
        chk("out_opA", bus.out_opA, m.a);
        chk("out_opB", bus.out_opB, m.b);
      end
      if (!rst) chk("in_ready", bus.in_ready, exp_rdy);
    end
    // Delivery order: each consumed output must be the oldest live accepted instruction.
    if (m_known && m.v && bus.out_ready && !rst) begin
      if (sbq.size() == 0) chk("sb_empty", 1, 0);
      else chk("sb_order", bus.out_ctrl, sbq.pop_front());
    end
    nx = m;
    if (rst) begin
      nx = '0;
      sbq.delete();
    end else if (bus.flush) begin
      nx.v = 1'b0;
      sbq.delete();
    end else if (acc) begin
      nx.v    = 1'b1;
      nx.ctrl = bus.in_ctrl;
      nx.sa   = bus.in_srcA;
      nx.sb   = bus.in_srcB;
`ifdef REG_READ_BYPASS_EN
      nx.a = wb_view(rf[bus.in_srcA], bus.in_srcA);
      nx.b = wb_view(rf[bus.in_srcB], bus.in_srcB);
`else
      nx.a = rf[bus.in_srcA];
      nx.b = rf[bus.in_srcB];
`endif
      sbq.push_back(bus.in_ctrl);
    end else if (m.v && bus.out_ready) begin
      nx.v = 1'b0;
    end else if (m.v) begin
      nx.a = wb_view(m.a, m.sa);
      nx.b = wb_view(m.b, m.sb);
    end
    @(posedge clk);
    #1;
    if (bus.wb_we) rf[bus.wb_regDest] = wb_view(rf[bus.wb_regDest], bus.wb_regDest);
    m       = nx;
    m_known = 1;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid   = 0; bus.in_ctrl = '0; bus.in_srcA = 0; bus.in_srcB = 0;
    bus.wb_we      = 0; bus.wb_hb = 0; bus.wb_lb = 0;
    bus.wb_regDest = 0; bus.wb_dataIn = 0;
    bus.flush      = 0; bus.out_ready = 1;
  endtask

  task automatic set_wb(logic we, logic [2:0] d, logic hb, logic lb, logic [15:0] data);
    bus.wb_we = we; bus.wb_regDest = d; bus.wb_hb = hb; bus.wb_lb = lb; bus.wb_dataIn = data;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    m = '0;
    idle();
    rst = 1;
    // 1: reset
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_opA", bus.out_opA, 16'h0);
    chk("rst_opB", bus.out_opB, 16'h0);
    chk("rst_ctrl", bus.out_ctrl, '0);
    chk("rst_ready", bus.in_ready, 1);

    // 2: read r3 while its high byte is being written
    rf[3] = 16'h1234;
    bus.in_valid = 1; bus.in_srcA = 3; bus.in_srcB = 0; bus.in_ctrl = CW'(2);
    set_wb(1, 3, 1, 0, 16'hABCD);
`ifdef REG_READ_BYPASS_EN
    tick();
`else
    #1 chk("raw_stall_ready", bus.in_ready, 0);
    tick();
    set_wb(0, 0, 0, 0, 0);
    #1 chk("raw_retry_ready", bus.in_ready, 1);
    tick();
`endif
    chk("t2_valid", bus.out_valid, 1);
    chk("t2_opA", bus.out_opA, 16'hAB34);

    // 3: held operand refreshed by a low-byte writeback
    idle(); tick();
    rf[5] = 16'h0000;
    bus.out_ready = 0;
    bus.in_valid = 1; bus.in_srcA = 1; bus.in_srcB = 5; bus.in_ctrl = CW'(3);
    tick();
    chk("t3_opB_before", bus.out_opB, 16'h0000);
    bus.in_valid = 0;
    set_wb(1, 5, 0, 1, 16'h00FF);
    tick();
    chk("t3_opB_after", bus.out_opB, 16'h00FF);
    chk("t3_hold", bus.out_valid, 1);
    chk("t3_ctrl", bus.out_ctrl, CW'(3));

    // 4: flush kills held instruction and blocks the presented one
    set_wb(0, 0, 0, 0, 0);
    bus.flush = 1; bus.in_valid = 1; bus.in_ctrl = CW'(4); bus.in_srcA = 2; bus.in_srcB = 3;
    #1 chk("t4_flush_ready", bus.in_ready, 0);
    tick();
    chk("t4_flushed", bus.out_valid, 0);
    bus.flush = 0;
    #1 chk("t4_retry_ready", bus.in_ready, 1);
    tick();
    chk("t4_valid", bus.out_valid, 1);
    chk("t4_ctrl", bus.out_ctrl, CW'(4));

    // 5: back-to-back stream
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1; bus.in_ctrl = CW'(10 + i);
      bus.in_srcA = 3'($urandom_range(0, 7)); bus.in_srcB = 3'($urandom_range(0, 7));
      tick();
      chk("t5_ctrl", bus.out_ctrl, CW'(10 + i));
    end
    idle(); tick();

    // 6: same register on both sources
    rf[2] = 16'h1111;
    bus.in_valid = 1; bus.in_srcA = 2; bus.in_srcB = 2; bus.in_ctrl = CW'(6);
    set_wb(1, 2, 1, 1, 16'h5A5A);
    tick();
`ifndef REG_READ_BYPASS_EN
    set_wb(0, 0, 0, 0, 0);
    tick();
`endif
    chk("t6_opA", bus.out_opA, 16'h5A5A);
    chk("t6_opB", bus.out_opB, 16'h5A5A);
    rf[2] = 16'h7777;
    bus.in_ctrl = CW'(7);
    set_wb(0, 2, 1, 1, 16'hFFFF);
    tick();
    chk("t6_nowe_opA", bus.out_opA, 16'h7777);
    chk("t6_nowe_opB", bus.out_opB, 16'h7777);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_ctrl    = CW'($urandom);
      bus.in_srcA    = 3'($urandom_range(0, 7));
      bus.in_srcB    = 3'($urandom_range(0, 7));
      bus.wb_we      = $urandom_range(0, 1);
      bus.wb_hb      = $urandom_range(0, 1);
      bus.wb_lb      = $urandom_range(0, 1);
      bus.wb_regDest = 3'($urandom_range(0, 7));
      bus.wb_dataIn  = 16'($urandom);
      bus.out_ready  = ($urandom_range(0, 9) < 6);
      bus.flush      = ($urandom_range(0, 19) == 0);
      tick();
    end
    rst = 0;
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
